// File: rtl/conv_window_scheduler_if.sv
// Pixel-in / line-buffer-write / window-out signal bundle for conv_window_scheduler.
interface conv_window_scheduler_if #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic          pix_valid;
  logic          pix_ready;
  logic          wr_en;
  logic [1:0]    wr_row_sel;
  logic [CW-1:0] wr_col;
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [1:0]    win_top_sel;
  logic          win_last;

  modport master (
    input  pix_valid, win_ready,
    output pix_ready, wr_en, wr_row_sel, wr_col,
           win_valid, win_row, win_col, win_top_sel, win_last
  );

  modport slave (
    output pix_valid, win_ready,
    input  pix_ready, wr_en, wr_row_sel, wr_col,
           win_valid, win_row, win_col, win_top_sel, win_last
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Line-buffer write addressing and 3x3 window sequencing for the conv MAC array.
module conv_window_scheduler #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  conv_window_scheduler_if.master bus,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [1:0]    phys_sel;
  logic [1:0]    phys_next;

  logic          win_valid_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  logic [1:0]    win_top_q;
  logic          win_last_q;

  logic accept;
  logic win_hs;
  logic win_load;
  logic last_pix;

  always_comb begin
    phys_next      = (phys_sel == 2'd2) ? 2'd0 : phys_sel + 2'd1;
    last_pix       = (r == R_LAST) && (c == C_LAST);
    bus.pix_ready  = (state == FILL) && (!win_valid_q || bus.win_ready);
    accept         = bus.pix_ready && bus.pix_valid;
    win_hs         = win_valid_q && bus.win_ready;
    win_load       = accept && (r >= RW'(2)) && (c >= CW'(2));
    bus.wr_en      = accept;
    bus.wr_row_sel = phys_sel;
    bus.wr_col     = c;
    bus.win_valid  = win_valid_q;
    bus.win_row    = win_row_q;
    bus.win_col    = win_col_q;
    bus.win_top_sel = win_top_q;
    bus.win_last   = win_last_q;
    busy           = (state != IDLE);
    frame_done     = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      r           <= '0;
      c           <= '0;
      phys_sel    <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_top_q   <= '0;
      win_last_q  <= 1'b0;
    end else if (abort && state != IDLE) begin
      state       <= IDLE;
      r           <= '0;
      c           <= '0;
      phys_sel    <= '0;
      win_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= FILL;
          r        <= '0;
          c        <= '0;
          phys_sel <= '0;
        end
        FILL:    if (accept && last_pix) state <= DRAIN;
        DRAIN:   if (win_hs && win_last_q) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        if (c == C_LAST) begin
          c        <= '0;
          r        <= (r == R_LAST) ? '0 : r + RW'(1);
          phys_sel <= phys_next;
        end else begin
          c <= c + CW'(1);
        end
      end

      // A fresh window overrides the clear from a same-cycle handshake,
      // which is what sustains one window per cycle.
      if (win_load) begin
        win_valid_q <= 1'b1;
        win_row_q   <= r - RW'(2);
        win_col_q   <= c - CW'(2);
        win_top_q   <= phys_next;
        win_last_q  <= last_pix;
      end else if (win_hs) begin
        win_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler with an index-based window/pixel model.
module tb_conv_window_scheduler;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int NP = W * H;
  localparam int NW = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic frame_done;

  conv_window_scheduler_if #(.IMG_W(W), .IMG_H(H)) bus ();

  conv_window_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .bus        (bus.master),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame phase, pixels accepted (m_n), windows handed off (m_k), window pending.
  // Pixel n sits at (n/W, n%W); window k sits at (k/(W-2), k%(W-2)).
  int m_state;  // 0 idle, 1 fill, 2 drain, 3 done
  int m_n;
  int m_k;
  bit m_wv;

  always @(posedge clk or negedge rst) begin
    bit pr, acc, hs;
    int k0;
    if (!rst) begin
      m_state = 0; m_n = 0; m_k = 0; m_wv = 0;
    end else begin
      pr  = (m_state == 1) && (!m_wv || bus.win_ready);
      acc = pr && bus.pix_valid;
      hs  = m_wv && bus.win_ready;
      k0  = m_k;
      if (abort && m_state != 0) begin
        m_state = 0; m_wv = 0; m_n = 0;
      end else begin
        if (hs) begin m_wv = 0; m_k++; end
        if (acc) begin
          if (m_n / W >= 2 && m_n % W >= 2) m_wv = 1;
          m_n++;
        end
        case (m_state)
          0: if (start) begin m_state = 1; m_n = 0; m_k = 0; end
          1: if (acc && m_n == NP) m_state = 2;
          2: if (hs && k0 == NW - 1) m_state = 3;
          default: m_state = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    bit pr, acc;
    int wr, wc;
    pr  = (m_state == 1) && (!m_wv || bus.win_ready);
    acc = pr && bus.pix_valid;
    chk("busy", busy, int'(m_state != 0));
    chk("frame_done", frame_done, int'(m_state == 3));
    chk("pix_ready", bus.pix_ready, pr);
    chk("wr_en", bus.wr_en, acc);
    if (acc) begin
      chk("wr_row_sel", bus.wr_row_sel, (m_n / W) % 3);
      chk("wr_col", bus.wr_col, m_n % W);
      if (m_n == 3 * W) chk("lit_wrap_r3c0_sel", bus.wr_row_sel, 0);
    end
    chk("win_valid", bus.win_valid, m_wv);
    if (m_wv) begin
      wr = m_k / (W - 2);
      wc = m_k % (W - 2);
      chk("win_row", bus.win_row, wr);
      chk("win_col", bus.win_col, wc);
      chk("win_top_sel", bus.win_top_sel, wr % 3);
      chk("win_last", bus.win_last, int'(m_k == NW - 1));
      if (m_k == 0) begin
        chk("lit_first_win_pixcnt", m_n, 59);
        chk("lit_first_win_top", bus.win_top_sel, 0);
      end
      if (m_k == 26)  chk("lit_row1_top", bus.win_top_sel, 1);
      if (m_k == 78)  chk("lit_row3_top", bus.win_top_sel, 0);
      if (m_k == 111) chk("lit_w111_col", bus.win_col, 7);
      if (m_k == 112) chk("lit_w112_col", bus.win_col, 8);
      if (m_k == 675) begin
        chk("lit_last_row", bus.win_row, 25);
        chk("lit_last_col", bus.win_col, 25);
        chk("lit_last_flag", bus.win_last, 1);
      end
    end
    if (m_state == 3) chk("lit_win_count", m_k, 676);
  end

  // mode 0: always ready, 1: stall 5 cycles at window 111, 2: random,
  // 3: hold win_ready low once in DRAIN and return after a few cycles.
  task automatic run_frame(input int mode, input bit start_mid, input int abort_at);
    int stall = 0;
    int drain = 0;
    bit aborted = 0;
    bit finished = 0;
    @(posedge clk); #1;
    start = 1; bus.pix_valid = 1; bus.win_ready = 1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      start = 0;
      abort = 0;
      if (m_state == 3) begin
        chk("lit_frame_done_pulse", frame_done, 1);
        finished = 1;
        break;
      end
      if (aborted && m_state == 0) begin finished = 1; break; end
      bus.pix_valid = 1;
      bus.win_ready = 1;
      case (mode)
        1: if (m_wv && m_k == 111 && stall < 5) begin bus.win_ready = 0; stall++; end
        2: begin
          bus.win_ready = ($urandom_range(0, 1) == 1);
          bus.pix_valid = ($urandom_range(0, 3) != 0);
        end
        3: if (m_state == 2) begin
          bus.win_ready = 0;
          drain++;
          if (drain > 3) begin finished = 1; break; end
        end
        default: ;
      endcase
      if (start_mid && m_n == 200) start = 1;
      if (abort_at >= 0 && m_n == abort_at && !aborted) begin
        abort = 1; bus.pix_valid = 0; aborted = 1;
      end
      @(posedge clk); #1;
    end
    if (!finished) chk("frame_timeout", 0, 1);
    if (mode == 1) chk("lit_stall_cycles", stall, 5);
    if (mode != 3 && !aborted) begin @(posedge clk); #1; end
    start = 0; abort = 0;
  endtask

  initial begin
    bus.pix_valid = 1; bus.win_ready = 1; rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_pix_ready", bus.pix_ready, 0);
    chk("lit_rst_win_valid", bus.win_valid, 0);
    chk("lit_rst_busy", busy, 0);
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_idle_busy", busy, 0);
    chk("lit_idle_pix_ready", bus.pix_ready, 0);

    run_frame(0, 1'b0, -1);
    run_frame(0, 1'b1, -1);
    run_frame(1, 1'b0, -1);
    run_frame(2, 1'b0, -1);

    run_frame(0, 1'b0, 300);
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_win_valid", bus.win_valid, 0);
    chk("lit_abort_no_done", frame_done, 0);
    run_frame(0, 1'b0, -1);

    run_frame(3, 1'b0, -1);
    chk("lit_drain_win_valid", bus.win_valid, 1);
    #2 rst = 0;
    #1;
    chk("lit_arst_busy", busy, 0);
    chk("lit_arst_win_valid", bus.win_valid, 0);
    chk("lit_arst_pix_ready", bus.pix_ready, 0);
    chk("lit_arst_frame_done", frame_done, 0);
    chk("lit_arst_wr_en", bus.wr_en, 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    run_frame(0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
